sccb_cfg_seq: RTL
=================

SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

Interface
REQ-001 SHALL have parameter REG_NUMBER, default 250: number of table entries, indices 0..REG_NUMBER-1.
REQ-002 SHALL have parameter ADDR_W, default 16: register address width; legal values 8 (OV7670-class) and 16 (OV5640-class).
REQ-003 SHALL have parameter CLK_KHZ, default 25: clk frequency in kHz, used for all ms-to-cycle conversion.
REQ-004 SHALL have parameter PWRUP_MS, default 20: wait after reset or start before the first entry.
REQ-005 SHALL have parameter AUTO_START, default 1: when 1, a sequence begins automatically on reset release.
REQ-006 SHALL have parameter MAX_RETRY, default 3: resend attempts per NACKed entry (used only under the macro in REQ-030).
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 start  in  1  pulse; restarts the sequence from entry 0; honoured only in IDLE or DONE.
REQ-010 tbl_idx  out  clog2(REG_NUMBER)  current table index.
REQ-011 tbl_entry  in  ADDR_W+9  entry fields {is_delay, addr, data}; combinational, valid in the same cycle as tbl_idx.
REQ-012 trig  out  1  one-cycle write request to the SCCB driver.
REQ-013 driver_addr  out  ADDR_W  register address; stable from trig until driver_end.
REQ-014 driver_data  out  8  register data; stable from trig until driver_end.
REQ-015 driver_end  in  1  one-cycle pulse marking transfer complete.
REQ-016 driver_nack  in  1  qualified by driver_end; 1 means the slave did not acknowledge.
REQ-017 cfg_busy  out  1  high while a sequence is in progress.
REQ-018 sccb_cfg_end  out  1  one-cycle pulse when the last entry completes.
REQ-019 cfg_err  out  1  sticky error flag; cleared by start.

Function
REQ-020 SHALL use the FSM states IDLE, PWRUP, FETCH, ISSUE, WAIT_END, DELAY, DONE.
REQ-021 PWRUP: SHALL count PWRUP_MS*CLK_KHZ cycles, then move to FETCH with idx=0.
REQ-022 FETCH with is_delay=0: SHALL register addr and data to the outputs and go to ISSUE.
REQ-023 FETCH with is_delay=1: SHALL go to DELAY for data*CLK_KHZ cycles, issue no write, then advance idx; data=0 gives no wait.
REQ-024 ISSUE: SHALL pulse trig for exactly one cycle, then go to WAIT_END; at most one transfer is outstanding.
REQ-025 WAIT_END: on driver_end, SHALL advance idx and go to FETCH; on the final entry it SHALL instead pulse sccb_cfg_end and go to DONE.
REQ-026 The index counter SHALL saturate; idx never exceeds REG_NUMBER-1, and no trig is issued in DONE or IDLE (no re-initialisation loop).
REQ-027 driver_end outside WAIT_END SHALL be ignored.
REQ-028 start arriving in the same cycle as driver_end while in DONE: start SHALL win and the sequence SHALL restart with PWRUP.
REQ-029 Delay and power-up counters SHALL be 32 bits wide, and the product SHALL be computed without truncation.

Configuration
REQ-030 With SCCB_CFG_RETRY_EN defined: a NACK SHALL re-ISSUE the same entry up to MAX_RETRY times; after exhaustion SHALL set cfg_err and skip to the next entry.
REQ-031 Without SCCB_CFG_RETRY_EN defined: a NACK SHALL set cfg_err and the sequence SHALL continue; no retry logic is synthesised.

Reset
REQ-032 On rst_n low: state=IDLE, trig=0, driver_addr=0, driver_data=0, tbl_idx=0, all counters=0, cfg_busy=0, sccb_cfg_end=0, cfg_err=0.
REQ-033 Reset asserted mid-transfer SHALL abort immediately; after release, AUTO_START=1 SHALL go to PWRUP and AUTO_START=0 SHALL stay in IDLE.

Structure
REQ-034 Package sccb_cfg_pkg SHALL hold the FSM state enum, the entry field offsets, and the ms-to-cycles constant function.
REQ-035 The register table SHALL live in sub-module sccb_cfg_rom (combinational case ROM indexed by tbl_idx); per-sensor variants swap only that ROM.

Verification
REQ-036 CLK_KHZ=2, PWRUP_MS=3, REG_NUMBER=4, AUTO_START=1; release reset -> first trig exactly 6 cycles after release, with idx 0.
REQ-037 Entry {0,16'h3008,8'h82}, driver_end 10 cycles after trig -> driver_addr=16'h3008 and driver_data=8'h82 held for those 10 cycles, next trig 2 cycles after driver_end.
REQ-038 Entry 1 = delay 5 ms, CLK_KHZ=2 -> 10 cycles with no trig between entry 0's driver_end and entry 2's trig.
REQ-039 Last entry driver_end -> sccb_cfg_end pulse 1 cycle, cfg_busy falls, no further trig for 1000 cycles; then start -> PWRUP restarts from idx 0.
REQ-040 With SCCB_CFG_RETRY_EN defined, MAX_RETRY=3, NACK forced on entry 2 -> 4 trigs with addr unchanged, cfg_err=1, entry 3 then issued; without the macro -> 1 trig, cfg_err=1.
REQ-041 Reset pulsed during WAIT_END -> trig=0 and idx=0 immediately, with all outputs at their REQ-032 values.

Source files
------------

// File: rtl/sccb_cfg_pkg.sv
// -----------------------------------------------------------------------------
// sccb_cfg_pkg
//
// Shared definitions for the SCCB register-table sequencer:
//   - cfg_state_t   : sequencer FSM states
//   - DATA_W / DATA_LSB / ADDR_LSB : bit layout of one table entry
//       entry = {is_delay, addr[ADDR_W-1:0], data[7:0]}
//   - delay_bit()   : position of the is_delay flag for a given address width
//   - entry_w()     : total entry width for a given address width
//   - ms_to_cycles(): milliseconds x kHz -> clock cycles, saturating at 32 bits
//
// Optional feature macro used by the sequencer: SCCB_CFG_RETRY_EN
// -----------------------------------------------------------------------------
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        FETCH,
        ISSUE,
        WAIT_END,
        DELAY,
        DONE
    } cfg_state_t;

    localparam int DATA_W   = 8;
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = DATA_W;

    function automatic int delay_bit(input int addr_w);
        return addr_w + DATA_W;
    endfunction

    function automatic int entry_w(input int addr_w);
        return addr_w + DATA_W + 1;
    endfunction

    // The product is formed at 64 bits so nothing is lost; a result that
    // does not fit the 32-bit counters saturates instead of wrapping to a
    // short wait.
    function automatic logic [31:0] ms_to_cycles(input logic [31:0] ms,
                                                 input logic [31:0] khz);
        logic [63:0] prod;
        prod = {32'd0, ms} * {32'd0, khz};
        if (prod[63:32] != 32'd0) begin
            return 32'hFFFF_FFFF;
        end
        return prod[31:0];
    endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// -----------------------------------------------------------------------------
// sccb_cfg_rom
//
// Combinational register table for the SCCB configuration sequencer.
// This is an OV5640-style bring-up table; other sensors swap only this file.
// Indices past the end of the real table return a zero-length delay entry,
// which the sequencer steps over without issuing a write.
//
// Parameters:
//   ADDR_W : register address width (8 or 16)
//   IDX_W  : width of the table index
// Ports:
//   idx    in   IDX_W         table index from the sequencer
//   entry  out  ADDR_W+9      {is_delay, addr, data}
// -----------------------------------------------------------------------------
module sccb_cfg_rom
    import sccb_cfg_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic [IDX_W-1:0]           idx,
    output logic [entry_w(ADDR_W)-1:0] entry
);

    // Raw entries are always written with a 16-bit address; narrower
    // sensors keep the low byte.
    logic [31:0] sel;
    logic [24:0] raw;

    always_comb begin
        sel = 32'(idx);
        raw = {1'b1, 16'h0000, 8'h00};
        case (sel)
            32'd0:   raw = {1'b0, 16'h3008, 8'h82};
            32'd1:   raw = {1'b1, 16'h0000, 8'h05};
            32'd2:   raw = {1'b0, 16'h3103, 8'h11};
            32'd3:   raw = {1'b0, 16'h3008, 8'h42};
            32'd4:   raw = {1'b0, 16'h3103, 8'h03};
            32'd5:   raw = {1'b0, 16'h3017, 8'hFF};
            32'd6:   raw = {1'b0, 16'h3018, 8'hFF};
            32'd7:   raw = {1'b0, 16'h3034, 8'h1A};
            32'd8:   raw = {1'b0, 16'h3035, 8'h11};
            32'd9:   raw = {1'b0, 16'h3036, 8'h46};
            32'd10:  raw = {1'b0, 16'h3037, 8'h13};
            32'd11:  raw = {1'b0, 16'h3108, 8'h01};
            32'd12:  raw = {1'b0, 16'h3630, 8'h36};
            32'd13:  raw = {1'b0, 16'h3631, 8'h0E};
            32'd14:  raw = {1'b0, 16'h3632, 8'hE2};
            32'd15:  raw = {1'b0, 16'h3633, 8'h12};
            32'd16:  raw = {1'b0, 16'h3008, 8'h02};
            default: raw = {1'b1, 16'h0000, 8'h00};
        endcase
    end

    assign entry = {raw[24], raw[8 +: ADDR_W], raw[7:0]};

endmodule

// File: rtl/sccb_cfg_seq.sv
// -----------------------------------------------------------------------------
// sccb_cfg_seq
//
// Walks a register table (sccb_cfg_rom, attached outside this block) and
// hands each write to an SCCB driver one at a time. Delay entries pause the
// walk for data milliseconds instead of writing.
//
// The power-up wait is measured from reset release (or the accepted start
// pulse) to the first trig: PWRUP_MS*CLK_KHZ cycles, with a floor of three
// cycles (IDLE, PWRUP, FETCH).
//
// Optional feature macro: SCCB_CFG_RETRY_EN
//   defined   : a NACKed write is re-issued up to MAX_RETRY times, then
//               cfg_err is set and the walk moves on
//   undefined : a NACK sets cfg_err and the walk moves on
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   start         in   restart pulse, accepted only in IDLE or DONE
//   tbl_idx       out  current table index
//   tbl_entry     in   {is_delay, addr, data} for tbl_idx, same cycle
//   trig          out  one-cycle write request to the driver
//   driver_addr   out  register address, held until driver_end
//   driver_data   out  register data, held until driver_end
//   driver_end    in   transfer complete pulse
//   driver_nack   in   NACK flag, qualified by driver_end
//   cfg_busy      out  sequence in progress
//   sccb_cfg_end  out  one-cycle pulse after the last entry
//   cfg_err       out  sticky error flag, cleared by an accepted start
// -----------------------------------------------------------------------------
module sccb_cfg_seq
    import sccb_cfg_pkg::*;
#(
    parameter int REG_NUMBER = 250,
    parameter int ADDR_W     = 16,
    parameter int CLK_KHZ    = 25,
    parameter int PWRUP_MS   = 20,
    parameter int AUTO_START = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start,
    output logic [((REG_NUMBER > 1) ? $clog2(REG_NUMBER) : 1)-1:0] tbl_idx,
    input  logic [entry_w(ADDR_W)-1:0]                           tbl_entry,
    output logic                                                 trig,
    output logic [ADDR_W-1:0]                                    driver_addr,
    output logic [7:0]                                           driver_data,
    input  logic                                                 driver_end,
    input  logic                                                 driver_nack,
    output logic                                                 cfg_busy,
    output logic                                                 sccb_cfg_end,
    output logic                                                 cfg_err
);

    localparam int               IDX_W        = (REG_NUMBER > 1) ? $clog2(REG_NUMBER) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(REG_NUMBER - 1);
    localparam int               DELAY_BIT    = delay_bit(ADDR_W);
    localparam logic [31:0]      PWRUP_CYCLES = ms_to_cycles(32'(PWRUP_MS), 32'(CLK_KHZ));
    // The counter starts at 1 on the PWRUP entry edge and FETCH adds one
    // more cycle, so PWRUP is left two cycles before the full count.
    localparam logic [31:0]      PWRUP_LAST   = (PWRUP_CYCLES > 32'd2) ? PWRUP_CYCLES - 32'd2 : 32'd0;

    if (ADDR_W != 8 && ADDR_W != 16) begin : g_addr_w_check
        $error("sccb_cfg_seq: ADDR_W must be 8 or 16");
    end
    if (MAX_RETRY < 0) begin : g_retry_check
        $error("sccb_cfg_seq: MAX_RETRY must be non-negative");
    end

    cfg_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       cnt_q;
    logic [31:0]       dly_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              err_q;
    logic              end_q;
    logic              auto_arm_q;

    logic              entry_is_delay;
    logic [ADDR_W-1:0] entry_addr;
    logic [7:0]        entry_data;
    logic [31:0]       entry_delay_cycles;
    logic              last_entry;

    logic advance;
    logic idx_clr, idx_inc;
    logic cnt_clr, cnt_one, cnt_inc;
    logic load_drv, load_dly;
    logic err_set, err_clr;
    logic end_set, arm_clr;

`ifdef SCCB_CFG_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_q;
    logic               retry_inc, retry_clr;
`endif

    assign entry_is_delay     = tbl_entry[DELAY_BIT];
    assign entry_addr         = tbl_entry[ADDR_LSB +: ADDR_W];
    assign entry_data         = tbl_entry[DATA_LSB +: DATA_W];
    assign entry_delay_cycles = ms_to_cycles({24'd0, entry_data}, 32'(CLK_KHZ));
    assign last_entry         = (idx_q == LAST_IDX);

    // Next-state logic and datapath strobes. Moving on from an entry is
    // funnelled through 'advance' so the last-entry handling lives in one
    // place: the final entry ends the run instead of bumping the index.
    always_comb begin
        state_d  = state_q;
        advance  = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_one  = 1'b0;
        cnt_inc  = 1'b0;
        load_drv = 1'b0;
        load_dly = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        end_set  = 1'b0;
        arm_clr  = 1'b0;
`ifdef SCCB_CFG_RETRY_EN
        retry_inc = 1'b0;
        retry_clr = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start || auto_arm_q) begin
                    state_d = PWRUP;
                    cnt_one = 1'b1;
                    idx_clr = 1'b1;
                    arm_clr = 1'b1;
                    err_clr = start;
                end
            end

            PWRUP: begin
                if (cnt_q >= PWRUP_LAST) begin
                    state_d = FETCH;
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            FETCH: begin
                if (entry_is_delay) begin
                    if (entry_delay_cycles == 32'd0) begin
                        advance = 1'b1;
                    end else begin
                        state_d  = DELAY;
                        load_dly = 1'b1;
                        cnt_one  = 1'b1;
                    end
                end else begin
                    state_d  = ISSUE;
                    load_drv = 1'b1;
                end
            end

            ISSUE: begin
                state_d = WAIT_END;
            end

            WAIT_END: begin
                if (driver_end) begin
                    if (driver_nack) begin
`ifdef SCCB_CFG_RETRY_EN
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            state_d   = ISSUE;
                            retry_inc = 1'b1;
                        end else begin
                            retry_clr = 1'b1;
                            err_set   = 1'b1;
                            advance   = 1'b1;
                        end
`else
                        err_set = 1'b1;
                        advance = 1'b1;
`endif
                    end else begin
`ifdef SCCB_CFG_RETRY_EN
                        retry_clr = 1'b1;
`endif
                        advance = 1'b1;
                    end
                end
            end

            DELAY: begin
                if (cnt_q >= dly_q) begin
                    cnt_clr = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            DONE: begin
                if (start) begin
                    state_d = PWRUP;
                    cnt_one = 1'b1;
                    idx_clr = 1'b1;
                    err_clr = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (last_entry) begin
                state_d = DONE;
                end_set = 1'b1;
            end else begin
                state_d = FETCH;
                idx_inc = 1'b1;
            end
        end
    end

    // State and datapath registers. The index and counters saturate so a
    // stray strobe can never wrap them back into the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            dly_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            end_q      <= 1'b0;
            auto_arm_q <= (AUTO_START != 0);
        end else begin
            state_q <= state_d;

            if (idx_clr) begin
                idx_q <= '0;
            end else if (idx_inc && (idx_q != LAST_IDX)) begin
                idx_q <= idx_q + 1'b1;
            end

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_one) begin
                cnt_q <= 32'd1;
            end else if (cnt_inc && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end

            if (load_dly) begin
                dly_q <= entry_delay_cycles;
            end

            if (load_drv) begin
                addr_q <= entry_addr;
                data_q <= entry_data;
            end

            if (err_clr) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end

            end_q <= end_set;

            if (arm_clr) begin
                auto_arm_q <= 1'b0;
            end
        end
    end

`ifdef SCCB_CFG_RETRY_EN
    // Retries are counted per entry and cleared whenever the entry is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q <= '0;
        end else if (retry_clr || (state_q == PWRUP)) begin
            retry_q <= '0;
        end else if (retry_inc) begin
            retry_q <= retry_q + 1'b1;
        end
    end
`endif

    assign tbl_idx      = idx_q;
    assign trig         = (state_q == ISSUE);
    assign driver_addr  = addr_q;
    assign driver_data  = data_q;
    assign cfg_busy     = (state_q != IDLE) && (state_q != DONE);
    assign sccb_cfg_end = end_q;
    assign cfg_err      = err_q;

endmodule
